vga_ram_arb: RTL and testbench
==============================

VGA_RAM_ARB -- requirements
Module: vga_ram_arb

Interface
REQ-001 Parameter IMG_W, default 160, image width in stored pixels.
REQ-002 Parameter IMG_H, default 120, image height in stored pixels.
REQ-003 Parameter FIFO_DEPTH, default 4, write-request FIFO entries (power of 2).
REQ-004 vga_clk  input  1  pixel clock; all logic on rising edge.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 pix_x  input  10  display column request from timing generator; 10'h3ff = no request.
REQ-007 pix_y  input  10  display row request; 10'h3ff = no request.
REQ-008 pix_data  output  16  RGB565 to timing generator, one cycle after request.
REQ-009 wr_valid  input  1  writer request valid.
REQ-010 wr_ready  output  1  FIFO not full; push when wr_valid & wr_ready.
REQ-011 wr_addr  input  15  writer word address.
REQ-012 wr_data  input  16  writer pixel.
REQ-013 ram_en, ram_we  output  1 each  single-port RAM enable / write enable.
REQ-014 ram_addr  output  15  RAM address.
REQ-015 ram_wdata  output  16  RAM write data.
REQ-016 ram_rdata  input  16  RAM read data, valid one cycle after read enable.
REQ-017 in_vblank  output  1  registered vertical-blank state flag.
REQ-018 frame_start  output  1  one-cycle pulse on first display request of a frame.
REQ-019 wr_err  output  1  one-cycle pulse when a popped entry has wr_addr >= IMG_W*IMG_H.

Function
REQ-020 Display request (disp_req) = pix_x != 10'h3ff; it SHALL always own the RAM that cycle.
REQ-021 Display address = (pix_y>>2)*IMG_W + (pix_x>>2), 15-bit, combinational; ram_en=1, ram_we=0.
REQ-022 rd_d1 register = disp_req delayed one cycle; pix_data = rd_d1 ? ram_rdata : 16'h0000.
REQ-023 Write FIFO: push on wr_valid & wr_ready; wr_ready = (registered level != FIFO_DEPTH); a pop in the same cycle does not raise wr_ready that cycle.
REQ-024 Pop (write grant) when FIFO non-empty, !disp_req and write window open (REQ-030); one pop per cycle max.
REQ-025 On grant with wr_addr < IMG_W*IMG_H: ram_en=1, ram_we=1, ram_addr=head addr, ram_wdata=head data.
REQ-026 On grant with out-of-range addr: entry discarded, ram_en=0, wr_err pulses next cycle.
REQ-027 No grant and no disp_req: ram_en=0, ram_we=0, ram_addr and ram_wdata = 0.
REQ-028 Frame FSM states VBLANK, ACTIVE. VBLANK->ACTIVE on disp_req (frame_start pulses next cycle); ACTIVE->VBLANK on disp_req with pix_x==639 and pix_y==479.
REQ-029 in_vblank = 1 in VBLANK, 0 in ACTIVE, updated one cycle after the transition condition.
REQ-030 Write window: see Configuration.
REQ-031 Simultaneous push and pop: level unchanged, ordering preserved (FIFO strict order).

Reset
REQ-032 On sys_rst_n low: FSM=VBLANK, in_vblank=1, FIFO empty (wr_ready=1), rd_d1=0 (pix_data=0), frame_start=0, wr_err=0.
REQ-033 Reset mid-operation discards all FIFO entries; no RAM write issued while reset asserted.

Configuration
REQ-034 Macro VGA_RAM_ARB_VBLANK_WR_EN defined: write window open only when FSM in VBLANK (tear-free writes).
REQ-035 Macro undefined: write window open on every cycle without disp_req (horizontal and vertical blanking).

Verification
REQ-036 Reset, then pix_x=0,pix_y=0 -> ram_addr=0, ram_en=1, ram_we=0; next cycle pix_data=ram_rdata; frame_start pulses.
REQ-037 pix_x=7,pix_y=9 -> ram_addr=2*160+1=321; pix_x=3ff -> next-cycle pix_data=16'h0000.
REQ-038 Push 5 writes back-to-back with disp_req held -> wr_ready=0 after 4th; no RAM write until disp_req drops.
REQ-039 Push addr 19200 during blanking -> no RAM write, wr_err pulses once, FIFO level decrements.
REQ-040 With VGA_RAM_ARB_VBLANK_WR_EN: write queued in ACTIVE horizontal blank stays pending until after request (639,479); without macro it drains in that horizontal blank.

Source files
------------

// File: rtl/vga_ram_arb.sv
// vga_ram_arb: shares one single-port frame-buffer RAM between VGA scan-out reads and a queued pixel writer.
// Optional feature macro VGA_RAM_ARB_VBLANK_WR_EN: when defined, queued writes drain only during vertical blank.
`timescale 1ns/1ps
module vga_ram_arb #(
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [15:0] pix_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [14:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        ram_en,
    output logic        ram_we,
    output logic [14:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        in_vblank,
    output logic        frame_start,
    output logic        wr_err
);

    // Writer handshake: an entry is taken on a rising edge where wr_valid and wr_ready are both high;
    // wr_ready reflects only the registered FIFO level, so wr_valid may wait on it without a loop.

    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               LVL_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [15:0]      PIX_LIMIT = 16'(IMG_W * IMG_H);
    localparam logic [14:0]      IMG_W_L   = 15'(IMG_W);
    localparam logic [9:0]       NO_REQ    = 10'h3ff;
    localparam logic [9:0]       LAST_X    = 10'd639;
    localparam logic [9:0]       LAST_Y    = 10'd479;

    typedef enum logic {
        ST_VBLANK = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_state_t;

    frame_state_t     r_state;
    frame_state_t     w_state_nxt;
    logic             w_frame_start_nxt;
    logic             r_frame_start;
    logic             r_wr_err;
    logic             r_rd_d1;

    logic [14:0]      r_fifo_addr [FIFO_DEPTH];
    logic [15:0]      r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic             w_disp_req;
    logic             w_last_pix;
    logic [14:0]      w_disp_addr;
    logic             w_fifo_empty;
    logic             w_wr_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_wr_window;
    logic [14:0]      w_head_addr;
    logic [15:0]      w_head_data;
    logic             w_head_in_range;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Display side: the row/column are downscaled by 4 into the stored image.
    assign w_disp_req  = (pix_x != NO_REQ);
    assign w_last_pix  = (pix_x == LAST_X) && (pix_y == LAST_Y);
    assign w_disp_addr = 15'(pix_y >> 2) * IMG_W_L + 15'(pix_x >> 2);

    assign w_fifo_empty    = (r_level == '0);
    assign w_wr_ready      = (r_level != LVL_FULL);
    assign w_push          = wr_valid & w_wr_ready;
    assign w_head_addr     = r_fifo_addr[r_rd_ptr];
    assign w_head_data     = r_fifo_data[r_rd_ptr];
    assign w_head_in_range = ({1'b0, w_head_addr} < PIX_LIMIT);

`ifdef VGA_RAM_ARB_VBLANK_WR_EN
    assign w_wr_window = (r_state == ST_VBLANK);
`else
    assign w_wr_window = 1'b1;
`endif

    // The display never waits: writes only get the cycles it leaves idle.
    assign w_pop = ~w_fifo_empty & ~w_disp_req & w_wr_window;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_disp_req) begin
            ram_en   = 1'b1;
            ram_addr = w_disp_addr;
        end else if (w_pop && w_head_in_range) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = w_head_addr;
            ram_wdata = w_head_data;
        end
    end

    // FIFO storage carries no reset; validity is tracked by the level and pointers.
    always_ff @(posedge vga_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_frame_start_nxt = 1'b0;
        unique case (r_state)
            ST_VBLANK: begin
                if (w_disp_req) begin
                    w_state_nxt       = ST_ACTIVE;
                    w_frame_start_nxt = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_disp_req && w_last_pix) w_state_nxt = ST_VBLANK;
            end
            default: w_state_nxt = ST_VBLANK;
        endcase
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= ST_VBLANK;
            r_frame_start <= 1'b0;
            r_wr_err      <= 1'b0;
            r_rd_d1       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_wr_err      <= w_pop & ~w_head_in_range;
            r_rd_d1       <= w_disp_req;
        end
    end

    assign pix_data    = r_rd_d1 ? ram_rdata : 16'h0000;
    assign wr_ready    = w_wr_ready;
    assign in_vblank   = (r_state == ST_VBLANK);
    assign frame_start = r_frame_start;
    assign wr_err      = r_wr_err;

endmodule

// File: tb/tb_vga_ram_arb.sv
// Bench for vga_ram_arb: directed scenarios with literal expectations, then random traffic against a queue/image model.
`timescale 1ns/1ps
module tb_vga_ram_arb;

    localparam int IMG_W      = 160;
    localparam int IMG_H      = 120;
    localparam int FIFO_DEPTH = 4;
    localparam int IMG_PIX    = IMG_W * IMG_H;
    localparam int MEM_WORDS  = 32768;

    logic        vga_clk;
    logic        sys_rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic        ram_en;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        in_vblank;
    logic        frame_start;
    logic        wr_err;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 0;

    vga_ram_arb #(.IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .in_vblank   (in_vblank),
        .frame_start (frame_start),
        .wr_err      (wr_err)
    );

    // Clock and reset
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Single-port RAM attached to the DUT, read data one cycle after the read.
    logic [15:0] ram_mem [MEM_WORDS];
    initial begin
        for (int a = 0; a < MEM_WORDS; a++) ram_mem[a] = 16'(a) ^ 16'h5A5A;
        forever begin
            @(posedge vga_clk);
            if (ram_en) begin
                if (ram_we) ram_mem[ram_addr] <= ram_wdata;
                else        ram_rdata <= ram_mem[ram_addr];
            end
        end
    end

    // Reference model: pending writes as a queue of {addr, data}, image contents as an array.
    logic [30:0] exp_q[$];
    logic [15:0] img [MEM_WORDS];
    bit          m_vblank      = 1'b1;
    bit          m_frame_start = 1'b0;
    bit          m_wr_err      = 1'b0;
    bit          m_rd_d1       = 1'b0;
    logic [15:0] m_pix         = 16'h0;

    function automatic int disp_addr(input logic [9:0] x, input logic [9:0] y);
        return ((int'(y) / 4) * IMG_W + int'(x) / 4) % MEM_WORDS;
    endfunction

    function automatic bit write_window();
`ifdef VGA_RAM_ARB_VBLANK_WR_EN
        return m_vblank;
`else
        return 1'b1;
`endif
    endfunction

    initial begin
        bit          disp;
        bit          push;
        bit          pop;
        logic [30:0] head;
        for (int a = 0; a < MEM_WORDS; a++) img[a] = 16'(a) ^ 16'h5A5A;
        forever begin
            @(posedge vga_clk or negedge sys_rst_n);
            if (!sys_rst_n) begin
                exp_q.delete();
                m_vblank      = 1'b1;
                m_frame_start = 1'b0;
                m_wr_err      = 1'b0;
                m_rd_d1       = 1'b0;
                m_pix         = 16'h0;
            end else begin
                disp     = (pix_x != 10'h3ff);
                push     = wr_valid && (exp_q.size() < FIFO_DEPTH);
                pop      = (exp_q.size() > 0) && !disp && write_window();
                m_wr_err = 1'b0;
                if (pop) begin
                    head = exp_q.pop_front();
                    if (int'(head[30:16]) < IMG_PIX) img[head[30:16]] = head[15:0];
                    else m_wr_err = 1'b1;
                end
                if (push) exp_q.push_back({wr_addr, wr_data});
                m_rd_d1       = disp;
                m_pix         = disp ? img[15'(disp_addr(pix_x, pix_y))] : 16'h0;
                m_frame_start = m_vblank && disp;
                if (m_vblank) begin
                    if (disp) m_vblank = 1'b0;
                end else if (disp && pix_x == 10'd639 && pix_y == 10'd479) begin
                    m_vblank = 1'b1;
                end
            end
        end
    end

    // Scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        logic        e_en;
        logic        e_we;
        logic [14:0] e_addr;
        logic [15:0] e_wd;
        logic [30:0] head;
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (pix_x != 10'h3ff) begin
            e_en   = 1'b1;
            e_addr = 15'(disp_addr(pix_x, pix_y));
        end else if (exp_q.size() > 0 && write_window()) begin
            head = exp_q[0];
            if (int'(head[30:16]) < IMG_PIX) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = head[30:16]; e_wd = head[15:0];
            end
        end
        chk("cyc_ram_en",      32'(ram_en),      32'(e_en));
        chk("cyc_ram_we",      32'(ram_we),      32'(e_we));
        chk("cyc_ram_addr",    32'(ram_addr),    32'(e_addr));
        chk("cyc_ram_wdata",   32'(ram_wdata),   32'(e_wd));
        chk("cyc_wr_ready",    32'(wr_ready),    32'(exp_q.size() != FIFO_DEPTH));
        chk("cyc_pix_data",    32'(pix_data),    32'(m_rd_d1 ? m_pix : 16'h0));
        chk("cyc_in_vblank",   32'(in_vblank),   32'(m_vblank));
        chk("cyc_frame_start", 32'(frame_start), 32'(m_frame_start));
        chk("cyc_wr_err",      32'(wr_err),      32'(m_wr_err));
    endtask

    initial begin
        forever begin
            @(negedge vga_clk);
            #2;
            if (cmp_on) compare_cycle();
        end
    end

    // Driver tasks
    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic v,
                         input logic [14:0] a, input logic [15:0] d);
        @(negedge vga_clk);
        pix_x = x; pix_y = y; wr_valid = v; wr_addr = a; wr_data = d;
        #3;
    endtask

    task automatic idle();
        drive(10'h3ff, 10'h3ff, 1'b0, 15'h0, 16'h0);
    endtask

    task automatic reset_dut(input int cycles);
        @(negedge vga_clk);
        sys_rst_n = 1'b0;
        pix_x = 10'h3ff; pix_y = 10'h3ff; wr_valid = 1'b0;
        #3;
        chk("rst_wr_ready",    32'(wr_ready),    32'd1);
        chk("rst_in_vblank",   32'(in_vblank),   32'd1);
        chk("rst_pix_data",    32'(pix_data),    32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_wr_err",      32'(wr_err),      32'd0);
        chk("rst_ram_we",      32'(ram_we),      32'd0);
        repeat (cycles) @(negedge vga_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        logic [9:0]  x;
        logic [9:0]  y;
        logic [14:0] a;
        int          r;
        sys_rst_n = 1'b0;
        pix_x = 10'h3ff; pix_y = 10'h3ff;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        @(posedge vga_clk);
        cmp_on = 1'b1;
        reset_dut(3);
        idle();

        // First request of a frame, address mapping, read latency
        drive(10'd0, 10'd0, 1'b0, 15'h0, 16'h0);
        chk("a_ram_addr", 32'(ram_addr), 32'd0);
        chk("a_ram_en",   32'(ram_en),   32'd1);
        chk("a_ram_we",   32'(ram_we),   32'd0);
        drive(10'd7, 10'd9, 1'b0, 15'h0, 16'h0);
        chk("b_ram_addr",    32'(ram_addr),    32'd321);
        chk("b_pix_data",    32'(pix_data),    32'h5A5A);
        chk("b_frame_start", 32'(frame_start), 32'd1);
        chk("b_in_vblank",   32'(in_vblank),   32'd0);
        idle();
        chk("c_pix_data",    32'(pix_data),    32'h5B1B);
        chk("c_frame_start", 32'(frame_start), 32'd0);
        idle();
        chk("d_pix_data",    32'(pix_data),    32'd0);

        // Five back-to-back pushes while the display owns the RAM
        for (int i = 0; i < 5; i++) begin
            drive(10'd8, 10'd8, 1'b1, 15'(100 + i), 16'(16'hC000 + i));
            chk("full_wr_ready", 32'(wr_ready), 32'(i < 4));
            chk("full_ram_we",   32'(ram_we),   32'd0);
        end
        drive(10'd8, 10'd8, 1'b0, 15'h0, 16'h0);
        chk("full_hold_we", 32'(ram_we), 32'd0);
`ifdef VGA_RAM_ARB_VBLANK_WR_EN
        idle();
        chk("hblank_pending_we", 32'(ram_we),   32'd0);
        chk("hblank_pending_rd", 32'(wr_ready), 32'd0);
        drive(10'd639, 10'd479, 1'b0, 15'h0, 16'h0);
        chk("last_pix_we", 32'(ram_we), 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("drain_we",    32'(ram_we),    32'd1);
            chk("drain_addr",  32'(ram_addr),  32'(100 + i));
            chk("drain_wdata", 32'(ram_wdata), 32'(16'hC000 + i));
        end
        idle();
        chk("drained_we",    32'(ram_we),   32'd0);
        chk("drained_ready", 32'(wr_ready), 32'd1);

        // Out-of-range write is dropped with a single error pulse
        drive(10'h3ff, 10'h3ff, 1'b1, 15'd19200, 16'hBEEF);
        chk("oor_push_ready", 32'(wr_ready), 32'd1);
        idle();
        chk("oor_pop_en",  32'(ram_en), 32'd0);
        chk("oor_pop_err", 32'(wr_err), 32'd0);
        idle();
        chk("oor_err_pulse", 32'(wr_err), 32'd1);
        chk("oor_ram_en",    32'(ram_en), 32'd0);
        idle();
        chk("oor_err_clear", 32'(wr_err), 32'd0);

        // Written pixel reads back through the display path
        drive(10'd400, 10'd0, 1'b0, 15'h0, 16'h0);
        chk("rb_ram_addr", 32'(ram_addr), 32'd100);
        idle();
        chk("rb_pix_data", 32'(pix_data), 32'hC000);

        // Reset with queued writes discards them
        for (int i = 0; i < 3; i++) drive(10'd8, 10'd8, 1'b1, 15'(200 + i), 16'(16'hD000 + i));
        reset_dut(2);
        idle();
        chk("flush_ram_en",    32'(ram_en),    32'd0);
        chk("flush_in_vblank", 32'(in_vblank), 32'd1);

        // Random traffic checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 35) begin
                x = 10'h3ff; y = 10'h3ff;
            end else if (r < 40) begin
                x = 10'd639; y = 10'd479;
            end else begin
                x = 10'($urandom_range(0, 639));
                y = 10'($urandom_range(0, 479));
            end
            if ($urandom_range(0, 19) == 0) a = 15'($urandom_range(IMG_PIX, MEM_WORDS - 1));
            else                            a = 15'($urandom_range(0, IMG_PIX - 1));
            drive(x, y, 1'($urandom_range(0, 1)), a, 16'($urandom));
            if (i == 1500) reset_dut(2);
        end
        repeat (4) idle();
        cmp_on = 1'b0;

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
